// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline stage with an elastic valid/ready handshake. The stage
//   carries the write-back control bundle, the memory read data, the ALU
//   result and the destination register index from MEM to WB. It holds at
//   most two entries: a main register that drives the outputs and a skid
//   register. In_Ready is computed from registered state only, so there is
//   no combinational path from Out_Ready back to In_Ready.
//
// Ports
//   Clk           in   clock, all state updates on posedge
//   Rst_n         in   synchronous reset, active-low
//   Flush         in   drop all held entries and the current input
//   In_Valid      in   upstream entry valid
//   In_Ready      out  stage can accept an entry this cycle
//   WB            in   write-back control bundle       [WB_W]
//   ReadData      in   memory read data                [DATA_W]
//   AluResult     in   ALU result / address            [DATA_W]
//   WriteReg      in   destination register index      [REG_W]
//   Out_Valid     out  *_OUT hold a valid entry
//   Out_Ready     in   downstream accepts entry this cycle
//   WB_OUT        out  registered WB                   [WB_W]
//   ReadData_OUT  out  registered ReadData             [DATA_W]
//   AluResult_OUT out  registered AluResult            [DATA_W]
//   WriteReg_OUT  out  registered WriteReg             [REG_W]
//   StallCount    out  output-stall cycle count        [STALL_CNT_W]
//
// Configuration
//   MEMWB_STALLCNT_EN  when defined, StallCount counts cycles with
//                      Out_Valid && !Out_Ready, saturating at all-ones and
//                      cleared only by reset. When undefined it is tied to 0.

module mem_wb_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Flush,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic [WB_W-1:0]        WB,
  input  logic [DATA_W-1:0]      ReadData,
  input  logic [DATA_W-1:0]      AluResult,
  input  logic [REG_W-1:0]       WriteReg,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [WB_W-1:0]        WB_OUT,
  output logic [DATA_W-1:0]      ReadData_OUT,
  output logic [DATA_W-1:0]      AluResult_OUT,
  output logic [REG_W-1:0]       WriteReg_OUT,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic              main_valid;
  logic              skid_valid;
  logic [WB_W-1:0]   skid_wb;
  logic [DATA_W-1:0] skid_read_data;
  logic [DATA_W-1:0] skid_alu_result;
  logic [REG_W-1:0]  skid_write_reg;

  logic accept;
  logic drain;

  // Ready depends only on the skid slot: while it is empty there is always
  // room, either in main or in skid.
  assign In_Ready  = Rst_n && !skid_valid;
  assign Out_Valid = main_valid;
  assign accept    = In_Valid && In_Ready;
  assign drain     = main_valid && Out_Ready;

  // The main register doubles as the output register. Skid only fills when
  // main is occupied and not draining; when main drains with skid full, the
  // skid entry moves forward (no accept is possible in that cycle because
  // In_Ready is low).
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      main_valid      <= 1'b0;
      skid_valid      <= 1'b0;
      WB_OUT          <= '0;
      ReadData_OUT    <= '0;
      AluResult_OUT   <= '0;
      WriteReg_OUT    <= '0;
      skid_wb         <= '0;
      skid_read_data  <= '0;
      skid_alu_result <= '0;
      skid_write_reg  <= '0;
    end else if (Flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        WB_OUT        <= skid_wb;
        ReadData_OUT  <= skid_read_data;
        AluResult_OUT <= skid_alu_result;
        WriteReg_OUT  <= skid_write_reg;
        main_valid    <= 1'b1;
        skid_valid    <= 1'b0;
      end else if (accept) begin
        WB_OUT        <= WB;
        ReadData_OUT  <= ReadData;
        AluResult_OUT <= AluResult;
        WriteReg_OUT  <= WriteReg;
        main_valid    <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        WB_OUT        <= WB;
        ReadData_OUT  <= ReadData;
        AluResult_OUT <= AluResult;
        WriteReg_OUT  <= WriteReg;
        main_valid    <= 1'b1;
      end else begin
        skid_wb         <= WB;
        skid_read_data  <= ReadData;
        skid_alu_result <= AluResult;
        skid_write_reg  <= WriteReg;
        skid_valid      <= 1'b1;
      end
    end
  end

`ifdef MEMWB_STALLCNT_EN
  logic [STALL_CNT_W-1:0] stall_count;

  // Flush does not clear the counter; it is a diagnostic that only reset
  // restarts. Saturation keeps it from wrapping on long stalls.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_count <= '0;
    end else if (main_valid && !Out_Ready && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  assign StallCount = stall_count;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Scoreboard bench for mem_wb_stage built with wide parameters
//   (DATA_W=64, REG_W=6, WB_W=4). A reference model treats the stage as a
//   depth-2 FIFO: it tracks occupancy, pushes every accepted entry into an
//   expected queue, and a separate monitor pops and compares whenever an
//   entry is transferred downstream. Directed sequences cover reset,
//   streaming, backpressure, flush and the stall counter; a random phase
//   follows.

module tb_mem_wb_stage;

  localparam int DATA_W      = 64;
  localparam int REG_W       = 6;
  localparam int WB_W        = 4;
  localparam int STALL_CNT_W = 16;
  localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  wr;
  } entry_t;

  logic                   Clk;
  logic                   Rst_n;
  logic                   Flush;
  logic                   In_Valid;
  logic                   In_Ready;
  logic [WB_W-1:0]        WB;
  logic [DATA_W-1:0]      ReadData;
  logic [DATA_W-1:0]      AluResult;
  logic [REG_W-1:0]       WriteReg;
  logic                   Out_Valid;
  logic                   Out_Ready;
  logic [WB_W-1:0]        WB_OUT;
  logic [DATA_W-1:0]      ReadData_OUT;
  logic [DATA_W-1:0]      AluResult_OUT;
  logic [REG_W-1:0]       WriteReg_OUT;
  logic [STALL_CNT_W-1:0] StallCount;

  int checks   = 0;
  int failures = 0;

  int     model_cnt   = 0;
  int     stall_model = 0;
  entry_t exp_q[$];
  logic   monitor_on  = 1'b0;

  mem_wb_stage #(
    .DATA_W(DATA_W),
    .REG_W(REG_W),
    .WB_W(WB_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Flush(Flush),
    .In_Valid(In_Valid),
    .In_Ready(In_Ready),
    .WB(WB),
    .ReadData(ReadData),
    .AluResult(AluResult),
    .WriteReg(WriteReg),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .WB_OUT(WB_OUT),
    .ReadData_OUT(ReadData_OUT),
    .AluResult_OUT(AluResult_OUT),
    .WriteReg_OUT(WriteReg_OUT),
    .StallCount(StallCount)
  );

  // 10 ns clock, posedges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference model: a FIFO of depth two. It accepts when reset is released
  // and fewer than two entries are held, emits when at least one is held and
  // the consumer is ready; flush and reset empty it.
  always @(posedge Clk) begin
    entry_t e;
    logic   acc;
    logic   drn;
    if (!Rst_n) begin
      model_cnt   = 0;
      stall_model = 0;
      exp_q.delete();
    end else begin
`ifdef MEMWB_STALLCNT_EN
      if (model_cnt > 0 && !Out_Ready && stall_model < STALL_MAX) stall_model++;
`endif
      if (Flush) begin
        model_cnt = 0;
        exp_q.delete();
      end else begin
        acc = In_Valid && (model_cnt < 2);
        drn = (model_cnt > 0) && Out_Ready;
        if (drn) model_cnt--;
        if (acc) begin
          model_cnt++;
          e.wb  = WB;
          e.rd  = ReadData;
          e.alu = AluResult;
          e.wr  = WriteReg;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: samples 1 ns before each posedge, checks handshake outputs
  // against the model and the presented entry against the queue head, and
  // retires the head on a transfer.
  initial begin
    entry_t got;
    @(posedge Clk);
    monitor_on = 1'b1;
    forever begin
      @(negedge Clk);
      #4;
      checks++;
      if (Out_Valid !== (model_cnt > 0)) begin
        failures++;
        $display("[TB] FAIL out_valid t=%0t actual=%b required=%b", $time, Out_Valid, (model_cnt > 0));
      end
      checks++;
      if (In_Ready !== (Rst_n && model_cnt < 2)) begin
        failures++;
        $display("[TB] FAIL in_ready t=%0t actual=%b required=%b", $time, In_Ready, (Rst_n && model_cnt < 2));
      end
      checks++;
      if (StallCount !== STALL_CNT_W'(stall_model)) begin
        failures++;
        $display("[TB] FAIL stall_count t=%0t actual=%0d required=%0d", $time, StallCount, stall_model);
      end
      if (model_cnt > 0 && exp_q.size() > 0) begin
        got = '{wb: WB_OUT, rd: ReadData_OUT, alu: AluResult_OUT, wr: WriteReg_OUT};
        checks++;
        if (got !== exp_q[0]) begin
          failures++;
          $display("[TB] FAIL out_data t=%0t actual=%h required=%h", $time, got, exp_q[0]);
        end
        if (Out_Ready && Rst_n && !Flush) void'(exp_q.pop_front());
      end
    end
  end

  // Drives one cycle of inputs at the negedge and returns 1 ns after the
  // following posedge, so callers can inspect the updated state.
  task automatic applyStimulus(input logic rstn, input logic fl, input logic v,
                               input logic [WB_W-1:0] wb, input logic [DATA_W-1:0] rd,
                               input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] wr,
                               input logic ordy);
    @(negedge Clk);
    Rst_n     = rstn;
    Flush     = fl;
    In_Valid  = v;
    WB        = wb;
    ReadData  = rd;
    AluResult = alu;
    WriteReg  = wr;
    Out_Ready = ordy;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, ordy);
  endtask

  task automatic push(input logic [DATA_W-1:0] alu, input logic ordy);
    applyStimulus(1'b1, 1'b0, 1'b1, WB_W'(alu), ~alu, alu, REG_W'(alu), ordy);
  endtask

  initial begin
    Rst_n = 1'b0; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    WB = '0; ReadData = '0; AluResult = '0; WriteReg = '0;

    // Reset held for two cycles with a valid input present.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 64'h1234, 64'h5678, 6'h3F, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 64'h1234, 64'h5678, 6'h3F, 1'b1);
    checkOutput("reset_out_valid", DATA_W'(Out_Valid), '0);
    checkOutput("reset_in_ready", DATA_W'(In_Ready), '0);
    checkOutput("reset_wb_out", DATA_W'(WB_OUT), '0);
    checkOutput("reset_read_data_out", ReadData_OUT, '0);
    checkOutput("reset_alu_out", AluResult_OUT, '0);
    checkOutput("reset_write_reg_out", DATA_W'(WriteReg_OUT), '0);
    checkOutput("reset_stall_count", DATA_W'(StallCount), '0);
    idle(1'b1);
    checkOutput("release_in_ready", DATA_W'(In_Ready), 1);

    // Streaming with the consumer always ready: one-cycle latency, no gaps.
    for (int k = 1; k <= 8; k++) begin
      push(DATA_W'(k), 1'b1);
      checkOutput("stream_alu", AluResult_OUT, DATA_W'(k));
      checkOutput("stream_valid", DATA_W'(Out_Valid), 1);
    end
    idle(1'b1);
    checkOutput("stream_empty", DATA_W'(Out_Valid), 0);

    // Backpressure: A in main, B in skid, C refused.
    push(64'h11, 1'b0);
    push(64'h22, 1'b0);
    checkOutput("bp_in_ready_full", DATA_W'(In_Ready), 0);
    push(64'h33, 1'b0);
    checkOutput("bp_hold_a", AluResult_OUT, 64'h11);
    idle(1'b1);
    checkOutput("bp_b_moves_up", AluResult_OUT, 64'h22);
    checkOutput("bp_in_ready_back", DATA_W'(In_Ready), 1);
    idle(1'b1);
    checkOutput("bp_drained", DATA_W'(Out_Valid), 0);

    // Flush with two entries held and a valid input in the same cycle.
    push(64'hA1, 1'b0);
    push(64'hA2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h5, 64'hBAD, 64'hBAD, 6'h01, 1'b0);
    checkOutput("flush_out_valid", DATA_W'(Out_Valid), 0);
    checkOutput("flush_in_ready", DATA_W'(In_Ready), 1);
    idle(1'b1);
    idle(1'b1);

    // Full-width data passes unmodified.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hA, 64'hDEADBEEF_CAFEF00D, 64'h0123456789ABCDEF, 6'h2A, 1'b0);
    checkOutput("width_read_data", ReadData_OUT, 64'hDEADBEEF_CAFEF00D);
    checkOutput("width_write_reg", DATA_W'(WriteReg_OUT), 64'h2A);
    idle(1'b1);
    idle(1'b1);

    // Stall counter: fresh reset, one entry, five stalled cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    push(64'h77, 1'b0);
    for (int k = 0; k < 5; k++) idle(1'b0);
`ifdef MEMWB_STALLCNT_EN
    checkOutput("stall_five", DATA_W'(StallCount), 5);
`else
    checkOutput("stall_disabled", DATA_W'(StallCount), 0);
`endif
    idle(1'b1);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      logic [DATA_W-1:0] r;
      r = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                    1'($urandom), WB_W'($urandom), {$urandom, $urandom}, r,
                    REG_W'($urandom), ($urandom_range(0, 2) != 0));
    end
    for (int k = 0; k < 4; k++) idle(1'b1);
    checkOutput("final_empty", DATA_W'(Out_Valid), 0);

    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
